sdram_emu: RTL and testbench
============================

SDRAM_EMU -- requirements
Module: sdram_emu

Interface
REQ-001 SHALL have parameter ROW_W, default 12: width of i_A and the row address.
REQ-002 SHALL have parameter COL_W, default 9: column address width; full-page length is 2^COL_W.
REQ-003 SHALL have parameter BANK_W, default 2: bank-select width.
REQ-004 SHALL have parameter MEM_AW, default 12: backing-store depth 2^MEM_AW words; index is the low MEM_AW bits of {bank,row,col}.
REQ-005 SHALL have parameter T_RCD, default 3: minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-006 SHALL have parameter T_RP, default 3: minimum cycles from PRECHARGE to ACTIVE.
REQ-007 SHALL have parameter T_RFC, default 9: minimum cycles from REFRESH to any non-NOP.
REQ-008 SHALL have parameter T_MRD, default 2: minimum cycles from LOAD MODE to any non-NOP.
REQ-009 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-010 SHALL have port i_reset, input, 1: reset, synchronous and active-high.
REQ-011 SHALL have port i_CSn, input, 1: chip select, active low; high decodes as NOP.
REQ-012 SHALL have ports i_RASn, i_CASn, i_WEn, input, 1 each: command pins.
REQ-013 SHALL have port i_BS, input, BANK_W: bank select.
REQ-014 SHALL have port i_A, input, ROW_W: row, column, A10 and mode-register bits.
REQ-015 SHALL have ports i_LDQM, i_UDQM, input, 1 each: byte masks for bits 7:0 and 15:8.
REQ-016 SHALL have port i_dq, input, 16: write data from the controller.
REQ-017 SHALL have port o_dq, output, 16: read data.
REQ-018 SHALL have port o_dq_oe, output, 1: high while o_dq carries a valid read word.
REQ-019 SHALL have port o_refr_cnt, output, 16: count of REFRESH commands, wrapping.
REQ-020 SHALL have port o_err, output, 1: sticky protocol-error flag.
REQ-021 SHALL have port o_err_code, output, 4: code of the first error captured.

Function
REQ-022 SHALL decode {RASn,CASn,WEn}: 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE, 001 REFRESH, 000 LOAD MODE, 111 NOP.
REQ-023 SHALL, on LOAD MODE, latch BL from A[2:0] (000=1, 001=2, 010=4, 011=8, 111=full page), CL from A[6:4] (2 or 3) and single-write mode from A9; any other BL or CL value flags error 9 and leaves the mode register unchanged.
REQ-024 SHALL keep an open flag and row register per bank; ACTIVE opens bank i_BS with row i_A; ACTIVE on a bank already open flags error 1 and replaces the row.
REQ-025 SHALL, on PRECHARGE, close all banks when A10=1 and only bank i_BS when A10=0.
REQ-026 SHALL ignore READ/WRITE to a closed bank and flag error 2; before the first valid LOAD MODE it SHALL ignore them and flag error 3.
REQ-027 SHALL run one burst at a time; the burst starts at column i_A[COL_W-1:0] and wraps sequentially inside its BL-aligned block; a full-page burst wraps at 2^COL_W and runs until terminated.
REQ-028 SHALL end the active burst on BURST TERMINATE, on a new READ/WRITE (which starts a new burst), or on PRECHARGE of the burst bank; read words already in the CL pipeline SHALL still be output.
REQ-029 SHALL store write data at the WRITE edge and at each of the following BL-1 edges (one word only when single-write mode is set); a DQM high on an edge masks its byte for that same edge.
REQ-030 SHALL, for a READ sampled at edge k, drive word n on o_dq with o_dq_oe=1 so that the controller samples it at edge k+CL+n; DQM high at edge j SHALL force o_dq_oe=0 for the word sampled at edge j+2.
REQ-031 SHALL increment o_refr_cnt on REFRESH; a REFRESH issued while any bank is open SHALL flag error 4.
REQ-032 SHALL, when several errors occur on one edge, capture the lowest code; later errors do not change o_err_code.

Reset
REQ-033 SHALL, while i_reset=1, close all banks, mark the mode unloaded, cancel bursts and pipelines, and drive o_dq=0, o_dq_oe=0, o_refr_cnt=0, o_err=0, o_err_code=0; memory contents SHALL be preserved. Asserting reset mid-burst SHALL take effect on the next edge.

Configuration
REQ-034 SHALL include the timing checker only when SDRAM_EMU_TIMING_CHK_EN is defined. A command issued at edge k+m after an earlier command at edge k, with m below the limit, flags: error 5 (tRCD), 6 (tRP), 7 (tRFC), 8 (tMRD). Spacing m equal to the limit is legal. Without the macro no timing counters are built and codes 5-8 never occur.

Verification
REQ-035 Reset, PRECHARGE A10=1, 2x REFRESH spaced 10 cycles, LOAD MODE 0x037 -> o_refr_cnt=2, CL=3, BL=full page, o_err=0.
REQ-036 ACTIVE row 5, WRITE col 0 with data 0x1000..0x1007, TERMINATE, then READ col 0 -> 0x1000..0x1007 sampled at edges k+3..k+10.
REQ-037 BL=4 write to col 6 with 0xA0..0xA3 -> words land at cols 6,7,4,5; UDQM=1 on the second word keeps that word's old high byte.
REQ-038 READ while the bank is closed -> o_err=1, o_err_code=2, o_dq_oe stays 0.
REQ-039 With SDRAM_EMU_TIMING_CHK_EN defined: READ 2 cycles after ACTIVE (T_RCD=3) -> o_err_code=5; the same sequence built without the macro -> o_err=0.

Source files
------------

// File: rtl/sdram_emu_if.sv
// rtl/sdram_emu_if.sv - SDRAM pin bundle between a controller (master) and sdram_emu (slave)
interface sdram_emu_if #(
  parameter int ROW_W  = 12,
  parameter int BANK_W = 2
);
  logic              i_CSn;
  logic              i_RASn;
  logic              i_CASn;
  logic              i_WEn;
  logic [BANK_W-1:0] i_BS;
  logic [ROW_W-1:0]  i_A;
  logic              i_LDQM;
  logic              i_UDQM;
  logic [15:0]       i_dq;
  logic [15:0]       o_dq;
  logic              o_dq_oe;
  logic [15:0]       o_refr_cnt;
  logic              o_err;
  logic [3:0]        o_err_code;

  modport master (
    output i_CSn, i_RASn, i_CASn, i_WEn, i_BS, i_A, i_LDQM, i_UDQM, i_dq,
    input  o_dq, o_dq_oe, o_refr_cnt, o_err, o_err_code
  );

  modport slave (
    input  i_CSn, i_RASn, i_CASn, i_WEn, i_BS, i_A, i_LDQM, i_UDQM, i_dq,
    output o_dq, o_dq_oe, o_refr_cnt, o_err, o_err_code
  );
endinterface

// File: rtl/sdram_emu.sv
// rtl/sdram_emu.sv - cycle-level SDRAM device emulator with protocol error capture
// Optional timing checker (tRCD/tRP/tRFC/tMRD) built only when SDRAM_EMU_TIMING_CHK_EN is defined.
module sdram_emu #(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int MEM_AW = 12,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 9,
  parameter int T_MRD  = 2
) (
  input logic         i_clk,
  input logic         i_reset,
  sdram_emu_if.slave  bus
);
  localparam int NB = 1 << BANK_W;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;

  if (ROW_W < 11 || COL_W < 3 || T_RCD < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1 || T_RFC > 254)
  begin : g_param_check
    $error("sdram_emu: unsupported parameter set");
  end

  state_e            state_q, state_d;
  logic [NB-1:0]     open_q, open_d;
  logic [ROW_W-1:0]  row_q [NB];
  logic [ROW_W-1:0]  row_d [NB];
  logic              mode_ok_q, mode_ok_d;
  logic [COL_W-1:0]  bl_mask_q, bl_mask_d;
  logic              bl_full_q, bl_full_d;
  logic              cl3_q, cl3_d;
  logic              single_wr_q, single_wr_d;
  logic [BANK_W-1:0] b_bank_q, b_bank_d;
  logic [ROW_W-1:0]  b_row_q, b_row_d;
  logic [COL_W-1:0]  b_col_q, b_col_d;
  logic [COL_W-1:0]  b_mask_q, b_mask_d;
  logic [COL_W-1:0]  b_cnt_q, b_cnt_d;
  logic              b_full_q, b_full_d;
  logic [15:0]       refr_q, refr_d;
  logic              err_q, err_d;
  logic [3:0]        code_q, code_d;

  logic [15:0]       dq_q;
  logic              dq_oe_q;
  logic              dqm_q;
  logic [1:0]        pipe_vld_q;
  logic [15:0]       pipe_dat_q [2];
  logic [15:0]       mem_q [0:(1<<MEM_AW)-1];

  cmd_e              cmd;
  logic              burst_end;
  logic [9:1]        err_vec;
  logic [3:0]        low_code;
  logic              mem_we;
  logic              gen_vld;
  logic [MEM_AW-1:0] acc_idx;
  logic [15:0]       gen_dat;
  logic              lmr_ok;
  logic [COL_W-1:0]  lmr_mask;
  logic              out_vld;
  logic [15:0]       out_dat;

  // Next column inside the burst's aligned block; an all-ones mask gives full-page wrap.
  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c, input logic [COL_W-1:0] m);
    return (c & ~m) | ((c + 1'b1) & m);
  endfunction

`ifdef SDRAM_EMU_TIMING_CHK_EN
  logic [7:0] t_act_q [NB];
  logic [7:0] t_act_d [NB];
  logic [7:0] t_pre_q [NB];
  logic [7:0] t_pre_d [NB];
  logic [7:0] t_ref_q, t_ref_d;
  logic [7:0] t_mrd_q, t_mrd_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction
`endif

  assign gen_dat = mem_q[acc_idx];

  always_comb begin
    state_d     = state_q;
    open_d      = open_q;
    row_d       = row_q;
    mode_ok_d   = mode_ok_q;
    bl_mask_d   = bl_mask_q;
    bl_full_d   = bl_full_q;
    cl3_d       = cl3_q;
    single_wr_d = single_wr_q;
    b_bank_d    = b_bank_q;
    b_row_d     = b_row_q;
    b_col_d     = b_col_q;
    b_mask_d    = b_mask_q;
    b_cnt_d     = b_cnt_q;
    b_full_d    = b_full_q;
    refr_d      = refr_q;
    err_d       = err_q;
    code_d      = code_q;
    err_vec     = '0;
    low_code    = '0;
    mem_we      = 1'b0;
    gen_vld     = 1'b0;
    lmr_ok      = 1'b1;
    lmr_mask    = '0;
    acc_idx     = MEM_AW'({b_bank_q, b_row_q, b_col_q});
    cmd         = bus.i_CSn ? CMD_NOP : cmd_e'({bus.i_RASn, bus.i_CASn, bus.i_WEn});
    burst_end   = (cmd == CMD_RD) || (cmd == CMD_WR) || (cmd == CMD_BST) ||
                  ((cmd == CMD_PRE) && (bus.i_A[10] || bus.i_BS == b_bank_q));

    if (state_q != ST_IDLE) begin
      if (burst_end) begin
        state_d = ST_IDLE;
      end else begin
        mem_we  = (state_q == ST_WRITE);
        gen_vld = (state_q == ST_READ);
        b_col_d = next_col(b_col_q, b_mask_q);
        if (!b_full_q) begin
          b_cnt_d = b_cnt_q - 1'b1;
          if (b_cnt_q == COL_W'(1)) state_d = ST_IDLE;
        end
      end
    end

    case (cmd)
      CMD_LMR: begin
        case (bus.i_A[2:0])
          3'b000:  lmr_mask = '0;
          3'b001:  lmr_mask = COL_W'(1);
          3'b010:  lmr_mask = COL_W'(3);
          3'b011:  lmr_mask = COL_W'(7);
          3'b111:  lmr_mask = '1;
          default: lmr_ok   = 1'b0;
        endcase
        if (lmr_ok && (bus.i_A[6:4] == 3'd2 || bus.i_A[6:4] == 3'd3)) begin
          mode_ok_d   = 1'b1;
          bl_mask_d   = lmr_mask;
          bl_full_d   = (bus.i_A[2:0] == 3'b111);
          cl3_d       = (bus.i_A[6:4] == 3'd3);
          single_wr_d = bus.i_A[9];
        end else begin
          err_vec[9] = 1'b1;
        end
      end
      CMD_REF: begin
        refr_d = refr_q + 16'd1;
        if (|open_q) err_vec[4] = 1'b1;
      end
      CMD_PRE: begin
        for (int b = 0; b < NB; b++)
          if (bus.i_A[10] || bus.i_BS == BANK_W'(b)) open_d[b] = 1'b0;
      end
      CMD_ACT: begin
        if (open_q[bus.i_BS]) err_vec[1] = 1'b1;
        open_d[bus.i_BS] = 1'b1;
        row_d[bus.i_BS]  = bus.i_A;
      end
      CMD_RD, CMD_WR: begin
        if (!open_q[bus.i_BS]) err_vec[2] = 1'b1;
        if (!mode_ok_q)        err_vec[3] = 1'b1;
        if (open_q[bus.i_BS] && mode_ok_q) begin
          // Word 0 is transferred on the command edge itself.
          acc_idx  = MEM_AW'({bus.i_BS, row_q[bus.i_BS], bus.i_A[COL_W-1:0]});
          mem_we   = (cmd == CMD_WR);
          gen_vld  = (cmd == CMD_RD);
          b_bank_d = bus.i_BS;
          b_row_d  = row_q[bus.i_BS];
          b_mask_d = bl_mask_q;
          b_full_d = bl_full_q;
          b_cnt_d  = bl_mask_q;
          b_col_d  = next_col(bus.i_A[COL_W-1:0], bl_mask_q);
          if ((cmd == CMD_WR && single_wr_q) || (bl_mask_q == '0 && !bl_full_q))
            state_d = ST_IDLE;
          else
            state_d = (cmd == CMD_RD) ? ST_READ : ST_WRITE;
        end
      end
      default: ;
    endcase

`ifdef SDRAM_EMU_TIMING_CHK_EN
    for (int b = 0; b < NB; b++) begin
      t_act_d[b] = sat_inc(t_act_q[b]);
      t_pre_d[b] = sat_inc(t_pre_q[b]);
    end
    t_ref_d = sat_inc(t_ref_q);
    t_mrd_d = sat_inc(t_mrd_q);
    if (cmd != CMD_NOP) begin
      if (t_ref_q < 8'(T_RFC)) err_vec[7] = 1'b1;
      if (t_mrd_q < 8'(T_MRD)) err_vec[8] = 1'b1;
    end
    case (cmd)
      CMD_RD, CMD_WR: if (t_act_q[bus.i_BS] < 8'(T_RCD)) err_vec[5] = 1'b1;
      CMD_ACT: begin
        if (t_pre_q[bus.i_BS] < 8'(T_RP)) err_vec[6] = 1'b1;
        t_act_d[bus.i_BS] = 8'd1;
      end
      CMD_PRE: begin
        for (int b = 0; b < NB; b++)
          if (bus.i_A[10] || bus.i_BS == BANK_W'(b)) t_pre_d[b] = 8'd1;
      end
      CMD_REF: t_ref_d = 8'd1;
      CMD_LMR: t_mrd_d = 8'd1;
      default: ;
    endcase
`endif

    for (int c = 9; c >= 1; c--)
      if (err_vec[c]) low_code = 4'(c);
    if (!err_q && |err_vec) begin
      err_d  = 1'b1;
      code_d = low_code;
    end
  end

  // Output stage is CL-1 registers behind word generation so the controller samples at k+CL+n.
  assign out_vld = cl3_q ? pipe_vld_q[1] : pipe_vld_q[0];
  assign out_dat = cl3_q ? pipe_dat_q[1] : pipe_dat_q[0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      open_q      <= '0;
      for (int b = 0; b < NB; b++) row_q[b] <= '0;
      mode_ok_q   <= 1'b0;
      bl_mask_q   <= '0;
      bl_full_q   <= 1'b0;
      cl3_q       <= 1'b0;
      single_wr_q <= 1'b0;
      b_bank_q    <= '0;
      b_row_q     <= '0;
      b_col_q     <= '0;
      b_mask_q    <= '0;
      b_cnt_q     <= '0;
      b_full_q    <= 1'b0;
      refr_q      <= '0;
      err_q       <= 1'b0;
      code_q      <= '0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      dqm_q       <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_dat_q[0] <= '0;
      pipe_dat_q[1] <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      row_q       <= row_d;
      mode_ok_q   <= mode_ok_d;
      bl_mask_q   <= bl_mask_d;
      bl_full_q   <= bl_full_d;
      cl3_q       <= cl3_d;
      single_wr_q <= single_wr_d;
      b_bank_q    <= b_bank_d;
      b_row_q     <= b_row_d;
      b_col_q     <= b_col_d;
      b_mask_q    <= b_mask_d;
      b_cnt_q     <= b_cnt_d;
      b_full_q    <= b_full_d;
      refr_q      <= refr_d;
      err_q       <= err_d;
      code_q      <= code_d;
      pipe_vld_q  <= {pipe_vld_q[0], gen_vld};
      pipe_dat_q[0] <= gen_dat;
      pipe_dat_q[1] <= pipe_dat_q[0];
      dqm_q       <= bus.i_LDQM | bus.i_UDQM;
      dq_oe_q     <= out_vld & ~dqm_q;
      dq_q        <= out_vld ? out_dat : 16'h0000;
    end
  end

`ifdef SDRAM_EMU_TIMING_CHK_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int b = 0; b < NB; b++) begin
        t_act_q[b] <= 8'hFF;
        t_pre_q[b] <= 8'hFF;
      end
      t_ref_q <= 8'hFF;
      t_mrd_q <= 8'hFF;
    end else begin
      t_act_q <= t_act_d;
      t_pre_q <= t_pre_d;
      t_ref_q <= t_ref_d;
      t_mrd_q <= t_mrd_d;
    end
  end
`endif

  // Backing store is never reset so its contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      if (!bus.i_LDQM) mem_q[acc_idx][7:0]  <= bus.i_dq[7:0];
      if (!bus.i_UDQM) mem_q[acc_idx][15:8] <= bus.i_dq[15:8];
    end
  end

  assign bus.o_dq       = dq_q;
  assign bus.o_dq_oe    = dq_oe_q;
  assign bus.o_refr_cnt = refr_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = code_q;
endmodule

// File: tb/tb_sdram_emu.sv
// tb/tb_sdram_emu.sv - scoreboard bench for sdram_emu (expectations follow SDRAM_EMU_TIMING_CHK_EN)
`timescale 1ns/1ps
module tb_sdram_emu;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  typedef struct {
    int          edge_n;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_k = 0;
  exp_t sbq [$];
  exp_t got_e;
  logic [15:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sdram_emu_if #(.ROW_W(12), .BANK_W(2)) bus ();

  sdram_emu dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Word valid at this negedge is what the controller samples at the next rising edge.
  always @(negedge clk) begin
    if (bus.o_dq_oe === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read edge %0d got %h required no word", cyc + 1, bus.o_dq);
      end else begin
        got_e = sbq.pop_front();
        if (bus.o_dq !== got_e.data) begin
          errors++;
          $display("FAIL read_data edge %0d got %h required %h", cyc + 1, bus.o_dq, got_e.data);
        end
        checks++;
        if (cyc + 1 != got_e.edge_n) begin
          errors++;
          $display("FAIL read_edge got %0d required %0d", cyc + 1, got_e.edge_n);
        end
      end
    end
  end

  function automatic int idx(input int b, input int r, input int c);
    return ((b << 21) | (r << 9) | c) & 4095;
  endfunction

  function automatic logic [15:0] mdl_get(input int i);
    return mdl.exists(i) ? mdl[i] : 16'h0000;
  endfunction

  task automatic model_write(input int b, input int r, input int c, input logic [15:0] d,
                             input logic lm, input logic um);
    logic [15:0] old;
    old = mdl_get(idx(b, r, c));
    mdl[idx(b, r, c)] = {um ? old[15:8] : d[15:8], lm ? old[7:0] : d[7:0]};
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] bs, input logic [11:0] a,
                       input logic [15:0] d, input logic lm, input logic um);
    bus.i_CSn = 1'b0;
    {bus.i_RASn, bus.i_CASn, bus.i_WEn} = c;
    bus.i_BS = bs;
    bus.i_A = a;
    bus.i_dq = d;
    bus.i_LDQM = lm;
    bus.i_UDQM = um;
    last_k = cyc + 1;
    @(posedge clk); #1;
    bus.i_CSn = 1'b1;
    {bus.i_RASn, bus.i_CASn, bus.i_WEn} = C_NOP;
    bus.i_LDQM = 1'b0;
    bus.i_UDQM = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Push words first_n..last_n of a CL=3 read issued at last_k.
  task automatic expect_read(input int b, input int r, input int col, input int bl_len,
                             input int first_n, input int last_n);
    for (int n = first_n; n <= last_n; n++) begin
      int   c;
      exp_t e;
      c = (col & ~(bl_len - 1)) | ((col + n) & (bl_len - 1));
      e.edge_n = last_k + 3 + n;
      e.data = mdl_get(idx(b, r, c));
      sbq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words pending required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks += 5;
    if (bus.o_dq !== 16'h0)       begin errors++; $display("FAIL reset_dq got %h required 0000", bus.o_dq); end
    if (bus.o_dq_oe !== 1'b0)     begin errors++; $display("FAIL reset_oe got %b required 0", bus.o_dq_oe); end
    if (bus.o_refr_cnt !== 16'h0) begin errors++; $display("FAIL reset_refr got %0d required 0", bus.o_refr_cnt); end
    if (bus.o_err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b required 0", bus.o_err); end
    if (bus.o_err_code !== 4'h0)  begin errors++; $display("FAIL reset_code got %0d required 0", bus.o_err_code); end
    rst = 1'b0;
  endtask

  task automatic test_init;
    issue(C_PRE, 2'd0, 12'h400, 16'h0, 1'b0, 1'b0);
    idle(1);
    issue(C_REF, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
    idle(9);
    issue(C_REF, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
    idle(9);
    issue(C_LMR, 2'd0, 12'h037, 16'h0, 1'b0, 1'b0);
    idle(3);
    checks += 2;
    if (bus.o_refr_cnt !== 16'd2) begin errors++; $display("FAIL init_refr got %0d required 2", bus.o_refr_cnt); end
    if (bus.o_err !== 1'b0)       begin errors++; $display("FAIL init_err got %b required 0", bus.o_err); end
  endtask

  task automatic test_full_page;
    issue(C_ACT, 2'd0, 12'd5, 16'h0, 1'b0, 1'b0);
    idle(2);
    issue(C_WR, 2'd0, 12'd0, 16'h1000, 1'b0, 1'b0);
    model_write(0, 5, 0, 16'h1000, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      issue(C_NOP, 2'd0, 12'd0, 16'h1000 + 16'(i), 1'b0, 1'b0);
      model_write(0, 5, i, 16'h1000 + 16'(i), 1'b0, 1'b0);
    end
    issue(C_BST, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    idle(1);
    issue(C_RD, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    expect_read(0, 5, 0, 512, 0, 7);
    for (int i = 1; i < 8; i++) issue(C_NOP, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    issue(C_BST, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    wait_drain("full_page");
  endtask

  task automatic test_back_to_back;
    issue(C_LMR, 2'd0, 12'h032, 16'h0, 1'b0, 1'b0);
    idle(2);
    issue(C_WR, 2'd0, 12'd6, 16'h00A0, 1'b0, 1'b0);
    model_write(0, 5, 6, 16'h00A0, 1'b0, 1'b0);
    issue(C_NOP, 2'd0, 12'd0, 16'h00A1, 1'b0, 1'b1);
    model_write(0, 5, 7, 16'h00A1, 1'b0, 1'b1);
    issue(C_NOP, 2'd0, 12'd0, 16'h00A2, 1'b0, 1'b0);
    model_write(0, 5, 4, 16'h00A2, 1'b0, 1'b0);
    issue(C_NOP, 2'd0, 12'd0, 16'h00A3, 1'b0, 1'b0);
    model_write(0, 5, 5, 16'h00A3, 1'b0, 1'b0);
    idle(1);
    issue(C_RD, 2'd0, 12'd4, 16'h0, 1'b0, 1'b0);
    expect_read(0, 5, 4, 4, 0, 1);
    issue(C_NOP, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    issue(C_RD, 2'd0, 12'd6, 16'h0, 1'b0, 1'b0);
    expect_read(0, 5, 6, 4, 0, 3);
    idle(4);
    wait_drain("back_to_back");
  endtask

  task automatic test_read_dqm;
    issue(C_RD, 2'd0, 12'd4, 16'h0, 1'b0, 1'b0);
    expect_read(0, 5, 4, 4, 1, 3);
    issue(C_NOP, 2'd0, 12'd0, 16'h0, 1'b1, 1'b0);
    idle(3);
    wait_drain("read_dqm");
  endtask

  task automatic test_closed_read;
    issue(C_PRE, 2'd0, 12'h000, 16'h0, 1'b0, 1'b0);
    idle(1);
    issue(C_RD, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    idle(6);
    checks += 2;
    if (bus.o_err !== 1'b1)      begin errors++; $display("FAIL closed_err got %b required 1", bus.o_err); end
    if (bus.o_err_code !== 4'd2) begin errors++; $display("FAIL closed_code got %0d required 2", bus.o_err_code); end
    wait_drain("closed_read");
  endtask

  task automatic test_reset_mid_burst;
    issue(C_ACT, 2'd0, 12'd5, 16'h0, 1'b0, 1'b0);
    idle(2);
    issue(C_RD, 2'd0, 12'd0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    checks += 2;
    if (bus.o_err !== 1'b0)       begin errors++; $display("FAIL midreset_err got %b required 0", bus.o_err); end
    if (bus.o_refr_cnt !== 16'd0) begin errors++; $display("FAIL midreset_refr got %0d required 0", bus.o_refr_cnt); end
    wait_drain("mid_reset");
  endtask

  task automatic test_timing;
    logic       exp_err;
    logic [3:0] exp_code;
`ifdef SDRAM_EMU_TIMING_CHK_EN
    exp_err = 1'b1; exp_code = 4'd5;
`else
    exp_err = 1'b0; exp_code = 4'd0;
`endif
    issue(C_LMR, 2'd0, 12'h030, 16'h0, 1'b0, 1'b0);
    idle(1);
    issue(C_ACT, 2'd1, 12'd2, 16'h0, 1'b0, 1'b0);
    idle(2);
    issue(C_WR, 2'd1, 12'd0, 16'h5A5A, 1'b0, 1'b0);
    model_write(1, 2, 0, 16'h5A5A, 1'b0, 1'b0);
    issue(C_PRE, 2'd1, 12'h000, 16'h0, 1'b0, 1'b0);
    idle(2);
    issue(C_ACT, 2'd1, 12'd2, 16'h0, 1'b0, 1'b0);
    checks++;
    if (bus.o_err !== 1'b0) begin errors++; $display("FAIL timing_legal got %b required 0", bus.o_err); end
    idle(1);
    issue(C_RD, 2'd1, 12'd0, 16'h0, 1'b0, 1'b0);
    expect_read(1, 2, 0, 1, 0, 0);
    idle(5);
    wait_drain("timing");
    checks += 2;
    if (bus.o_err !== exp_err)       begin errors++; $display("FAIL timing_err got %b required %b", bus.o_err, exp_err); end
    if (bus.o_err_code !== exp_code) begin errors++; $display("FAIL timing_code got %0d required %0d", bus.o_err_code, exp_code); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_CSn = 1'b1;
    {bus.i_RASn, bus.i_CASn, bus.i_WEn} = C_NOP;
    bus.i_BS = '0;
    bus.i_A = '0;
    bus.i_dq = '0;
    bus.i_LDQM = 1'b0;
    bus.i_UDQM = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_init;
    test_full_page;
    test_back_to_back;
    test_read_dqm;
    test_closed_read;
    test_reset_mid_burst;
    test_timing;
    test_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
